peak_level_detector: RTL and testbench

PEAK_LEVEL_DETECTOR -- requirements
Module: peak_level_detector

---
 rtl/peak_level_detector.sv | 47 ++++
 tb/tb_peak_level_detector.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/peak_level_detector.sv
// peak_level_detector: windowed peak |sample| detector with valid/ready handshakes on input and result
module peak_level_detector #(
  parameter int WIDTH = 16,
  parameter int WINDOW_LENGTH = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-2:0] o_level
);
  localparam int CW = WINDOW_LENGTH > 1 ? $clog2(WINDOW_LENGTH) : 1;
  typedef enum logic {ACCUM, EMIT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-2:0] peak, mag, peak_max;
  logic [WIDTH-1:0] neg;
  logic take, last;
  assign neg = -i_data;
  assign mag = !i_data[WIDTH-1] ? i_data[WIDTH-2:0] : neg[WIDTH-1] ? '1 : neg[WIDTH-2:0];
  assign peak_max = mag > peak ? mag : peak;
  assign last = cnt == CW'(WINDOW_LENGTH - 1);
  assign take = i_valid && o_ready;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= ACCUM;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    o_ready = state == ACCUM;
    o_valid = state == EMIT;
    if (state == ACCUM) state_nxt = take && last ? EMIT : ACCUM;
    else state_nxt = i_ready ? ACCUM : EMIT;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      cnt <= '0;
      peak <= '0;
      o_level <= '0;
    end else if (take) begin
      cnt <= last ? '0 : cnt + CW'(1);
      peak <= last ? '0 : peak_max;
      if (last) o_level <= peak_max;
    end
endmodule

// File: tb/tb_peak_level_detector.sv
// tb_peak_level_detector: directed checks of the WINDOW_LENGTH=4 and WINDOW_LENGTH=1 configurations
module tb_peak_level_detector;
  logic clk = 0, rst_n = 0;
  logic valid = 0, ready = 1, o_ready, o_valid;
  logic [15:0] data = 0;
  logic [14:0] o_level;
  logic v1 = 0, r1 = 1, o_ready1, o_valid1;
  logic [15:0] d1 = 0;
  logic [14:0] o_level1;
  int total = 0, bad = 0;
  int vals1[3] = '{7, -9, 3};
  int exp1[3] = '{7, 9, 3};
  always #5 clk = ~clk;
  peak_level_detector #(.WIDTH(16), .WINDOW_LENGTH(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_data(data), .o_valid(o_valid), .i_ready(ready), .o_level(o_level)
  );
  peak_level_detector #(.WIDTH(16), .WINDOW_LENGTH(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(v1), .o_ready(o_ready1),
    .i_data(d1), .o_valid(o_valid1), .i_ready(r1), .o_level(o_level1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic push(input int d);
    int n = 0;
    @(negedge clk);
    valid = 1;
    data = 16'(d);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_rdy", o_ready, 1);
    @(posedge clk);
    #1 valid = 0;
  endtask
  task automatic consume();
    @(posedge clk);
    #1;
    chk("cons_v", o_valid, 0);
    chk("cons_r", o_ready, 1);
  endtask
  task automatic window(input string tag, input int a, input int b, input int c, input int d, input int exp);
    push(a);
    push(b);
    push(c);
    chk({tag, "_pre"}, o_valid, 0);
    push(d);
    chk({tag, "_v"}, o_valid, 1);
    chk({tag, "_r"}, o_ready, 0);
    chk({tag, "_lvl"}, o_level, exp);
    consume();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_r", o_ready, 1);
    chk("rst_v", o_valid, 0);
    chk("rst_lvl", o_level, 0);
    rst_n = 1;
    window("basic", 100, -300, 200, 50, 300);
    window("sat_neg", -32768, 0, 0, 0, 32767);
    window("sat_pos", 32767, -32767, 1, 1, 32767);
    window("mixed", -5, -2, 3, -1, 5);
    window("zero", 0, 0, 0, 0, 0);
    ready = 0;
    push(1);
    push(2);
    push(3);
    push(4);
    chk("bp_v0", o_valid, 1);
    @(negedge clk);
    valid = 1;
    data = 16'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_v", o_valid, 1);
      chk("bp_lvl", o_level, 4);
      chk("bp_r", o_ready, 0);
    end
    @(negedge clk);
    ready = 1;
    @(posedge clk);
    #1;
    chk("bp_cons_v", o_valid, 0);
    chk("bp_cons_r", o_ready, 1);
    @(posedge clk);
    #1 valid = 0;
    push(8);
    push(7);
    chk("bp_pre", o_valid, 0);
    push(6);
    chk("bp2_v", o_valid, 1);
    chk("bp2_lvl", o_level, 9);
    consume();
    chk("hold_lvl", o_level, 9);
    foreach (vals1[k]) begin end
    begin
      int g[4] = '{100, -300, 200, 50};
      foreach (g[k]) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push(g[k]);
        if (k < 3) chk("gap_pre", o_valid, 0);
      end
      chk("gap_v", o_valid, 1);
      chk("gap_lvl", o_level, 300);
      consume();
    end
    push(5000);
    push(6000);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_lvl", o_level, 0);
    chk("mid_rst_r", o_ready, 1);
    @(negedge clk);
    rst_n = 1;
    window("after_rst", 10, 20, 30, 40, 40);
    @(negedge clk);
    v1 = 1;
    foreach (vals1[k]) begin
      d1 = 16'(vals1[k]);
      @(posedge clk);
      #1;
      chk("wl1_v", o_valid1, 1);
      chk("wl1_r", o_ready1, 0);
      chk("wl1_lvl", o_level1, exp1[k]);
      @(posedge clk);
      #1;
      chk("wl1_cons_v", o_valid1, 0);
      chk("wl1_cons_r", o_ready1, 1);
    end
    v1 = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
